fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width.
REQ-002 SHALL have parameter MAX_nDATA, default 1126, maximum words per transfer.
REQ-003 SHALL have parameter WIDTH_CONFIGBITS, default $clog2(MAX_nDATA), width of the word count.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a transfer.
REQ-007 SHALL have port n_data  input  WIDTH_CONFIGBITS  words to read; sampled on accepted start.
REQ-008 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-009 SHALL have port fifo_data  input  WIDTH  FIFO read data, valid exactly 1 cycle after fifo_re.
REQ-010 SHALL have port fifo_re  output  1  FIFO read enable.
REQ-011 SHALL have port fifo_clear  output  1  FIFO clear pulse.
REQ-012 SHALL have port m_valid / m_ready / m_data[WIDTH] / m_last  out/in/out/out  downstream valid-ready stream.
REQ-013 SHALL have port busy  output  1  transfer in progress.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-016 IDLE: start=1 latches n_data into remaining and moves to RUN; n_data=0 moves directly to DONE with no reads.
REQ-017 start SHALL be ignored in any state other than IDLE.
REQ-018 RUN: fifo_re=1 iff fifo_empty=0, remaining>0, and (buffered + in-flight words) < 2; each read decrements remaining by 1.
REQ-019 RUN SHALL move to FLUSH in the cycle the last read issues (remaining 1->0).
REQ-020 FLUSH SHALL hold until the in-flight word is captured and the buffer has drained (last beat accepted), then move to DONE.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-022 Returned data SHALL go into a 2-entry skid buffer; a word is never dropped or duplicated, and order is preserved.
REQ-023 m_valid SHALL stay high with m_data stable until m_ready=1.
REQ-024 m_last SHALL be 1 only on the beat carrying word n_data of the transfer.
REQ-025 With a continuously non-empty FIFO and m_ready=1, throughput SHALL be 1 word/cycle; latency from fifo_re to m_valid SHALL be 2 cycles.
REQ-026 busy SHALL be 1 in RUN, FLUSH, and DONE, and 0 in IDLE.
REQ-027 Counter arithmetic SHALL be unsigned WIDTH_CONFIGBITS-bit; remaining never decrements below 0.

Reset
REQ-028 rst=0 SHALL asynchronously force IDLE, remaining=0, buffer empty, and in-flight cleared.
REQ-029 While rst=0, fifo_re, fifo_clear, m_valid, m_last, busy, and done SHALL all be 0, and m_data SHALL be 0.
REQ-030 Reset mid-transfer SHALL abandon the transfer; no done pulse is issued.

Configuration
REQ-031 Macro FIFO_READER_CLEAR_EN defined: fifo_clear SHALL pulse 1 in the DONE cycle.
REQ-032 Macro FIFO_READER_CLEAR_EN undefined: fifo_clear SHALL be constant 0; all other behaviour is unchanged.

Structure
REQ-033 Package fifo_reader_pkg SHALL hold the state enum type and the default WIDTH/MAX_nDATA constants.
REQ-034 The skid buffer SHALL be sub-module fifo_reader_skid (parameter WIDTH, 2 entries, valid-ready on both sides).

Verification
REQ-035 n_data=4, FIFO holds 4 words, m_ready=1: fifo_re high 4 consecutive cycles; 4 beats in order; m_last on beat 4; done 1 cycle after last beat.
REQ-036 n_data=0 start: no fifo_re; done pulses 1 cycle after start; busy is high for exactly that 1 cycle.
REQ-037 n_data=8, m_ready toggles 1/0 every cycle: all 8 words delivered in order, with no loss and no duplication; fifo_re never leaves more than 2 words outstanding.
REQ-038 n_data=3, fifo_empty=1 for 5 cycles after start: fifo_re stays low; reads resume when the FIFO is non-empty; 3 beats are delivered.
REQ-039 rst=0 asserted after 2 of 6 beats: all outputs are 0 immediately; after release the block is in IDLE, and a new start with n_data=2 completes normally.
REQ-040 With FIFO_READER_CLEAR_EN defined, n_data=1: fifo_clear is 1 only in the done cycle; with the macro undefined, fifo_clear stays 0.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// Shared types and default constants for the FIFO reader block.
package fifo_reader_pkg;

  localparam int FR_WIDTH_DEFAULT     = 16;
  localparam int FR_MAX_NDATA_DEFAULT = 1126;
  localparam int FR_SKID_DEPTH        = 2;

  // Transfer sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } fr_state_e;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry skid buffer with valid/ready on both sides. Storage is a tiny
// circular buffer; o_count exposes occupancy so the producer can run on
// credit instead of waiting on o_ready.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH = FR_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [FR_SKID_DEPTH];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  // A full buffer can still accept a word when its head leaves this cycle.
  assign o_valid = (r_count != 2'd0);
  assign o_ready = (r_count != 2'(FR_SKID_DEPTH)) || i_ready;
  assign w_push  = i_valid && o_ready;
  assign w_pop   = o_valid && i_ready;
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

  // Entry storage; cleared on reset so the output bus reads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FR_SKID_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      r_wptr <= r_wptr ^ w_push;
      r_rptr <= r_rptr ^ w_pop;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Reads n_data words from a 1-cycle-latency FIFO and streams them out over
// valid/ready with m_last on the final word. Reads are issued on credit so
// at most two words are ever buffered or in flight.
// Optional feature: define FIFO_READER_CLEAR_EN to pulse fifo_clear in the
// DONE cycle; otherwise fifo_clear is tied low.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH            = FR_WIDTH_DEFAULT,
  parameter int MAX_nDATA        = FR_MAX_NDATA_DEFAULT,
  parameter int WIDTH_CONFIGBITS = $clog2(MAX_nDATA)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WIDTH_CONFIGBITS-1:0] n_data,
  input  logic                        fifo_empty,
  input  logic [WIDTH-1:0]            fifo_data,
  output logic                        fifo_re,
  output logic                        fifo_clear,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [WIDTH-1:0]            m_data,
  output logic                        m_last,
  output logic                        busy,
  output logic                        done
);

  localparam int WC = WIDTH_CONFIGBITS;

  fr_state_e       r_state;
  fr_state_e       w_state_next;
  logic [WC-1:0]   r_remaining;
  logic [WC-1:0]   w_remaining_next;
  logic            r_inflight;
  logic            r_inflight_last;
  logic            w_fifo_re;
  logic            w_pop;
  logic            w_skid_ready;
  logic [1:0]      w_skid_count;
  logic [2:0]      w_occ;
  logic [WIDTH:0]  w_skid_out;

  // Occupancy after this cycle's output beat leaves: counting the departing
  // beat as gone is what allows one read per cycle in steady state.
  assign w_pop = m_valid && m_ready;
  assign w_occ = {1'b0, w_skid_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  // Next-state, read enable and remaining-count update.
  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    w_fifo_re        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_remaining_next = n_data;
          w_state_next     = (n_data == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // w_skid_ready is implied by the credit check; kept as a safety net.
        w_fifo_re = !fifo_empty && (r_remaining != '0) && (w_occ < 3'd2) && w_skid_ready;
        if (w_fifo_re) begin
          w_remaining_next = r_remaining - WC'(1);
          if (r_remaining == WC'(1)) begin
            w_state_next = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (w_occ == 3'd0) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State, counter and in-flight tracking registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ST_IDLE;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_remaining     <= w_remaining_next;
      r_inflight      <= w_fifo_re;
      r_inflight_last <= w_fifo_re && (r_remaining == WC'(1));
    end
  end

  // The last-word tag travels alongside the data through the buffer.
  fifo_reader_skid #(
    .WIDTH (WIDTH + 1)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_inflight),
    .o_ready (w_skid_ready),
    .i_data  ({r_inflight_last, fifo_data}),
    .o_valid (m_valid),
    .i_ready (m_ready),
    .o_data  (w_skid_out),
    .o_count (w_skid_count)
  );

  assign fifo_re = w_fifo_re;
  assign m_data  = w_skid_out[WIDTH-1:0];
  assign m_last  = w_skid_out[WIDTH] && m_valid;
  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);

`ifdef FIFO_READER_CLEAR_EN
  assign fifo_clear = (r_state == ST_DONE);
`else
  assign fifo_clear = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: table of transfer vectors plus a
// hand-written mid-transfer reset sequence. Expected beats are queued when
// words are loaded into the FIFO model and compared as the DUT emits them.
module tb_fifo_reader;

  localparam int W  = 16;
  localparam int WC = 11;

`ifdef FIFO_READER_CLEAR_EN
  localparam int EXP_CLR = 1;
`else
  localparam int EXP_CLR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [WC-1:0] n_data = '0;
  logic          fifo_empty;
  logic [W-1:0]  fifo_data = '0;
  logic          fifo_re;
  logic          fifo_clear;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  fifo_reader #(
    .WIDTH     (W),
    .MAX_nDATA (1126)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_data     (n_data),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_re    (fifo_re),
    .fifo_clear (fifo_clear),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    int n;
    bit toggle;
    int empty_cycles;
    bit restart;
    int exp_done;
    int exp_first;
    bit consec;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } sb_t;

  sb_t          sb_q[$];
  sb_t          mon_e;
  int           n_checks = 0;
  int           n_fail = 0;
  int           beats = 0;
  int           outstanding = 0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         prev_last = 1'b0;

  // FIFO model: one-cycle read latency, optional forced-empty window.
  logic [W-1:0] fmem [256];
  logic [7:0]   wr_ptr = '0;
  logic [7:0]   rd_ptr = '0;
  bit           force_empty = 1'b0;
  bit           tb_flush = 1'b0;

  assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (tb_flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_re && (rd_ptr != wr_ptr)) begin
      fifo_data <= fmem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      chk("re_when_empty", int'(fifo_re && fifo_empty), 0);
      chk("outstanding_le2", int'(outstanding <= 2), 1);
      if (prev_stall) begin
        chk("hold_valid", int'(m_valid), 1);
        chk("hold_data", int'(m_data), int'(prev_data));
        chk("hold_last", int'(m_last), int'(prev_last));
      end
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data=%h with no word pending", m_data);
        end else begin
          mon_e = sb_q.pop_front();
          chk("beat_data", int'(m_data), int'(mon_e.d));
          chk("beat_last", int'(m_last), int'(mon_e.l));
        end
        beats = beats + 1;
        $display("beat %0d data=%h last=%b", beats, m_data, m_last);
      end
      outstanding = outstanding + int'(fifo_re) - int'(m_valid && m_ready);
      prev_stall  = m_valid && !m_ready;
      prev_data   = m_data;
      prev_last   = m_last;
    end
  end

  task automatic load_words(input int n);
    sb_t          e;
    logic [W-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = W'($urandom);
      fmem[wr_ptr] = w;
      wr_ptr = wr_ptr + 8'd1;
      e.d = w;
      e.l = (i == n - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_fifo_re"}, int'(fifo_re), 0);
    chk({tag, "_fifo_clear"}, int'(fifo_clear), 0);
    chk({tag, "_m_valid"}, int'(m_valid), 0);
    chk({tag, "_m_last"}, int'(m_last), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_m_data"}, int'(m_data), 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int reads = 0, busy_cyc = 0, done_cnt = 0, done_k = -1;
    int clr_cnt = 0, clr_bad = 0, first_re = -1, last_re = -1;
    int re_in_empty = 0, b0;
    b0 = beats;
    load_words(v.n);
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      start       = (k == 0) || (v.restart && (k == 2));
      n_data      = (k == 0) ? WC'(v.n) : WC'(7);
      m_ready     = v.toggle ? (k % 2 == 0) : 1'b1;
      force_empty = (k < v.empty_cycles);
      @(negedge clk);
      if (fifo_re) begin
        reads++;
        if (first_re < 0) first_re = k;
        last_re = k;
        if (k < v.empty_cycles) re_in_empty++;
      end
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (fifo_clear) begin
        clr_cnt++;
        if (!done) clr_bad++;
      end
      if ((done_k >= 0) && (k >= done_k + 2)) break;
    end
    @(posedge clk);
    #1;
    start       = 1'b0;
    m_ready     = 1'b1;
    force_empty = 1'b0;
    chk("done_seen", int'(done_k >= 0), 1);
    chk("reads", reads, v.n);
    chk("beats", beats - b0, v.n);
    chk("done_pulses", done_cnt, 1);
    chk("busy_cycles", busy_cyc, done_k);
    if (v.exp_done >= 0) chk("done_latency", done_k, v.exp_done);
    chk("re_while_empty", re_in_empty, 0);
    chk("clear_pulses", clr_cnt, EXP_CLR);
    chk("clear_outside_done", clr_bad, 0);
    chk("sb_leftover", sb_q.size(), 0);
    if (v.exp_first >= 0) chk("first_re", first_re, v.exp_first);
    if (v.consec) chk("re_consecutive", last_re - first_re + 1, reads);
    sb_q.delete();
    $display("vec %0d n=%0d reads=%0d beats=%0d done_cycle=%0d", idx, v.n, reads, beats - b0, done_k);
  endtask

  vec_t vecs[6];
  vec_t v_after_rst;

  initial begin
    int b0;
    int seen_done;
    bit got;
    //          n  tog empty rst  done first consec
    vecs[0] = '{4, 0,  0,    0,   7,   1,    1};
    vecs[1] = '{0, 0,  0,    0,   1,  -1,    0};
    vecs[2] = '{8, 1,  0,    0,  -1,   1,    0};
    vecs[3] = '{3, 0,  5,    0,  10,   5,    1};
    vecs[4] = '{4, 0,  0,    1,   7,   1,    1};
    vecs[5] = '{1, 0,  0,    0,   4,   1,    1};
    v_after_rst = '{2, 0, 0, 0, 5, 1, 1};

    #3;
    check_outputs_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset in the middle of a 6-word transfer, after two beats.
    b0 = beats;
    seen_done = 0;
    got = 1'b0;
    load_words(6);
    @(posedge clk);
    #1;
    start  = 1'b1;
    n_data = WC'(6);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      if (done) seen_done++;
      if (beats - b0 >= 2) begin
        got = 1'b1;
        break;
      end
    end
    chk("mid_reset_two_beats", int'(got), 1);
    rst = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    sb_q.delete();
    tb_flush = 1'b1;
    @(posedge clk);
    #1;
    tb_flush = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) seen_done++;
      chk("post_reset_idle_busy", int'(busy), 0);
      chk("post_reset_idle_valid", int'(m_valid), 0);
    end
    chk("no_done_after_abandon", seen_done, 0);
    $display("mid-transfer reset after %0d beats", beats - b0);
    run_vec(6, v_after_rst);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
